// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM sequencing FETCH/DCD and the
// per-class execute states, decoding datapath controls from the held IR fields.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       OF,
    output logic       PCWr,
    output logic       IRWr,
    output logic [1:0] NPCSel,
    output logic       RFWr,
    output logic       RegDst,
    output logic       WDSel,
    output logic       ExtOp,
    output logic       ALUSrc,
    output logic [2:0] ALUctr,
    output logic       DMWr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MWB   = 4'd4,
        S_MW    = 4'd5,
        S_EXE   = 4'd6,
        S_AWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    state_e state_q, state_d;

    logic is_rtype, r_add, r_addu, r_subu, r_slt, r_ok;
    logic is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
    logic is_alu_op, ovf_trap;
    logic [2:0] exe_alu;

    always_comb begin
        is_rtype  = (op == OP_RTYPE);
        r_add     = is_rtype && (funct == FN_ADD);
        r_addu    = is_rtype && (funct == FN_ADDU);
        r_subu    = is_rtype && (funct == FN_SUBU);
        r_slt     = is_rtype && (funct == FN_SLT);
        r_ok      = r_add || r_addu || r_subu || r_slt;
        is_addi   = (op == OP_ADDI);
        is_ori    = (op == OP_ORI);
        is_lui    = (op == OP_LUI);
        is_lw     = (op == OP_LW);
        is_sw     = (op == OP_SW);
        is_beq    = (op == OP_BEQ);
        is_j      = (op == OP_J);
        is_alu_op = r_ok || is_addi || is_ori || is_lui;
        // Only the trapping adds drop their writeback on signed overflow.
        ovf_trap  = (r_add || is_addi) && OF;
    end

    always_comb begin
        exe_alu = ALU_ADD;
        if (r_subu)      exe_alu = ALU_SUB;
        else if (r_slt)  exe_alu = ALU_SLT;
        else if (is_ori) exe_alu = ALU_OR;
        else if (is_lui) exe_alu = ALU_LUI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                if (is_lw || is_sw)  state_d = S_MA;
                else if (is_alu_op)  state_d = S_EXE;
                else if (is_beq)     state_d = S_BR;
                else if (is_j)       state_d = S_JMP;
                else                 state_d = S_FETCH;
            end
            S_MA:    state_d = is_lw ? S_MR : S_MW;
            S_MR:    state_d = S_MWB;
            S_MWB:   state_d = S_FETCH;
            S_MW:    state_d = S_FETCH;
            S_EXE:   state_d = S_AWB;
            S_AWB:   state_d = S_FETCH;
            S_BR:    state_d = S_FETCH;
            S_JMP:   state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every control, so FETCH strobes cannot fire while rst is high.
    always_comb begin
        PCWr   = 1'b0;
        IRWr   = 1'b0;
        NPCSel = 2'b00;
        RFWr   = 1'b0;
        RegDst = 1'b0;
        WDSel  = 1'b0;
        ExtOp  = 1'b0;
        ALUSrc = 1'b0;
        ALUctr = ALU_ADD;
        DMWr   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
                S_MA, S_MR: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                S_MW: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                    DMWr   = 1'b1;
                end
                S_MWB: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                    RFWr   = 1'b1;
                    WDSel  = 1'b1;
                end
                S_EXE, S_AWB: begin
                    ALUctr = exe_alu;
                    ALUSrc = is_addi || is_ori || is_lui;
                    ExtOp  = is_addi;
                    RegDst = is_rtype;
                    RFWr   = (state_q == S_AWB) && !ovf_trap;
                end
                S_BR: begin
                    ALUctr = ALU_SUB;
                    NPCSel = 2'b01;
                    PCWr   = zero;
                end
                S_JMP: begin
                    PCWr   = 1'b1;
                    NPCSel = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op  in  6  IR[31:26] opcode; held stable by IR outside FETCH.
REQ-005 funct  in  6  IR[5:0] function field; used only when op=000000.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 OF  in  1  ALU signed-overflow flag.
REQ-008 PCWr  out  1  PC write enable.
REQ-009 IRWr  out  1  IR write enable.
REQ-010 NPCSel  out  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 RFWr  out  1  register-file write enable.
REQ-012 RegDst  out  1  destination register: 0 = rt, 1 = rd.
REQ-013 WDSel  out  1  register write data: 0 = ALU result, 1 = data memory.
REQ-014 ExtOp  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
REQ-015 ALUSrc  out  1  ALU B operand: 0 = register, 1 = extended immediate.
REQ-016 ALUctr  out  3  ALU operation: 000 add, 001 sub, 010 or, 011 lui, 100 slt.
REQ-017 DMWr  out  1  data-memory write enable.
REQ-018 state  out  4  current state code, for debug.

Function
REQ-019 The block SHALL be a Moore FSM with these state codes: FETCH=0, DCD=1, MA=2, MR=3, MWB=4, MW=5, EXE=6, AWB=7, BR=8, JMP=9.
REQ-020 Supported instructions SHALL be:
- R-type (op=000000) with funct add=100000, addu=100001, subu=100011, slt=101010
- addi=001000, ori=001101, lui=001111
- lw=100011, sw=101011, beq=000100, j=000010
REQ-021 State transitions SHALL be:
- FETCH -> DCD
- DCD -> MA for lw/sw; EXE for supported R-type/addi/ori/lui; BR for beq; JMP for j; FETCH for any other op/funct
- MA -> MR for lw, MW for sw
- MR -> MWB -> FETCH
- MW -> FETCH
- EXE -> AWB -> FETCH
- BR -> FETCH
- JMP -> FETCH
REQ-022 Instruction latency SHALL be: lw 5 cycles; sw and ALU-type 4; beq and j 3; unsupported 2.
REQ-023 Outputs not set below SHALL be 0 (PCWr, IRWr, NPCSel, RFWr, RegDst, WDSel, ExtOp, ALUSrc, ALUctr, DMWr).
REQ-024 FETCH SHALL drive PCWr=1, IRWr=1, NPCSel=00.
REQ-025 MA, MR, MW and MWB SHALL drive ALUctr=000, ALUSrc=1, ExtOp=1.
REQ-026 MW SHALL additionally drive DMWr=1.
REQ-027 MWB SHALL additionally drive RFWr=1, WDSel=1, RegDst=0.
REQ-028 EXE and AWB SHALL drive ALUctr by instruction:
- add/addu/addi = 000
- subu = 001
- ori = 010
- lui = 011
- slt = 100
REQ-029 EXE and AWB SHALL drive ALUSrc=1 for addi/ori/lui and 0 for R-type.
REQ-030 EXE and AWB SHALL drive ExtOp=1 only for addi.
REQ-031 EXE and AWB SHALL drive RegDst=1 only for R-type.
REQ-032 In AWB, RFWr SHALL be 1, except RFWr=0 when the instruction is add or addi and OF=1 (overflow suppresses the write).
REQ-033 BR SHALL drive ALUctr=001, ALUSrc=0, NPCSel=01, PCWr=zero (combinational in that state).
REQ-034 JMP SHALL drive PCWr=1, NPCSel=10.
REQ-035 At most one of PCWr, RFWr, DMWr SHALL be high in any cycle, except FETCH, where PCWr and IRWr are both high.
REQ-036 The FSM SHALL never leave the legal state codes; any illegal code SHALL go to FETCH on the next edge.

Reset
REQ-037 While rst=1, state SHALL be FETCH (0) and all write strobes (PCWr, IRWr, RFWr, DMWr) SHALL be forced to 0; other outputs SHALL be 0.
REQ-038 Asserting rst in any state, mid-instruction, SHALL take effect immediately without waiting for clk; the partial instruction is abandoned and no strobe fires.
REQ-039 The first rising edge after rst falls SHALL execute FETCH with PCWr=IRWr=1.

Verification
REQ-040 Release reset, op=100011 (lw) -> state 0,1,2,3,4,0; RFWr=1 with WDSel=1 and RegDst=0 only in state 4; DMWr never high.
REQ-041 op=000000, funct=100001 (addu) -> states 0,1,6,7,0; ALUctr=000 in states 6 and 7; RFWr=1 and RegDst=1 in state 7 only.
REQ-042 op=000100 (beq): zero=1 gives PCWr=1 and NPCSel=01 in state 8; zero=0 gives PCWr=0 in state 8; next state 0 in both cases.
REQ-043 op=001000 (addi) with OF=1 in state 7 -> RFWr=0; with OF=0 -> RFWr=1; ALUctr=000 and ExtOp=1 in both cases.
REQ-044 op=101011 (sw) -> states 0,1,2,5,0 with DMWr=1 only in state 5; op=111111 -> states 0,1,0.
REQ-045 Assert rst asynchronously while in state 3 -> state=0 and all strobes 0 before the next clk edge; release -> a clean FETCH.
